// File: rtl/pipelined_block_adder.sv
// pipelined_block_adder
//
// Pipelined block-carry adder/subtractor. The operands are split into
// BLOCKCOUNT blocks of BITPERBLOCK bits. Each of the STAGES pipeline stages
// adds BLOCKSPERSTAGE blocks and registers its carry for the next stage, so
// no combinational carry path is longer than one stage's worth of blocks.
// A valid/ready handshake with global-stall backpressure wraps the pipeline.
//
// Optional feature macro: PIPELINED_BLOCK_ADDER_FLAGS_EN
//   defined   : o_v (signed overflow) and o_z (zero) are computed, and the
//               operand sign bits travel down the pipeline.
//   undefined : o_v and o_z are tied to 0 and no flag logic exists.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset (clears control and data)
//   i_valid  operand set valid           o_ready  operand set accepted
//   i_a,i_b  operands (N bits)           i_c      carry-in / borrow-in
//   i_sub    0: A+B+c, 1: A-B-c
//   o_valid  result valid                i_ready  downstream accepts result
//   o_s      sum/difference (N bits)     o_c      raw carry-out of top block
//   o_v      signed overflow             o_z      result is zero
module pipelined_block_adder #(
  parameter int BLOCKCOUNT     = 8,
  parameter int BITPERBLOCK    = 4,
  parameter int N              = 32,
  parameter int BLOCKSPERSTAGE = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_s,
  output logic         o_c,
  output logic         o_v,
  output logic         o_z
);

  localparam int STAGES = BLOCKCOUNT / BLOCKSPERSTAGE;
  localparam int SW     = BLOCKSPERSTAGE * BITPERBLOCK;

  if ((N != BLOCKCOUNT * BITPERBLOCK) || (BLOCKCOUNT % BLOCKSPERSTAGE != 0)) begin : g_param_check
    $fatal(1, "pipelined_block_adder: N must equal BLOCKCOUNT*BITPERBLOCK and BLOCKSPERSTAGE must divide BLOCKCOUNT");
  end

  // Per-stage registers. A and B are carried at full width; the bits below
  // the current stage are never read again and are trimmed by synthesis.
  logic [STAGES-1:0]        valid_q, valid_d;
  logic [STAGES-1:0]        carry_q, carry_d;
  logic [STAGES-1:0][N-1:0] sum_q, sum_d;
  logic [STAGES-1:0][N-1:0] a_q, a_d;
  logic [STAGES-1:0][N-1:0] b_q, b_d;

  // Inputs seen by each stage's adder slice.
  logic [STAGES-1:0]        in_v, in_c;
  logic [STAGES-1:0][N-1:0] in_a, in_b, in_s;

  logic [N-1:0]             b_eff;
  logic                     stall;
  logic [BITPERBLOCK:0]     blk;
  logic                     blk_c;

`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
  logic [STAGES-1:0] sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [STAGES-1:0] in_sa, in_sb;
`endif

  // Subtraction is A + ~B + 1; the borrow-in inverts the carry-in.
  assign b_eff = i_sub ? ~i_b : i_b;

  // One global stall: a result waiting at the output freezes every stage.
  assign stall   = valid_q[STAGES-1] & ~i_ready;
  assign o_ready = ~stall;

  always_comb begin : stage_inputs
    in_v[0] = i_valid;
    in_a[0] = i_a;
    in_b[0] = b_eff;
    in_c[0] = i_c ^ i_sub;
    in_s[0] = '0;
`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
    in_sa[0] = i_a[N-1];
    in_sb[0] = b_eff[N-1];
`endif
    for (int k = 1; k < STAGES; k++) begin
      in_v[k] = valid_q[k-1];
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_c[k] = carry_q[k-1];
      in_s[k] = sum_q[k-1];
`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
      in_sa[k] = sign_a_q[k-1];
      in_sb[k] = sign_b_q[k-1];
`endif
    end
  end

  always_comb begin : stage_adders
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    blk     = '0;
    blk_c   = 1'b0;
`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
`endif
    if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        blk_c    = in_c[k];
        sum_d[k] = in_s[k];
        // Ripple through this stage's blocks only.
        for (int j = 0; j < BLOCKSPERSTAGE; j++) begin
          blk = {1'b0, in_a[k][k*SW + j*BITPERBLOCK +: BITPERBLOCK]}
              + {1'b0, in_b[k][k*SW + j*BITPERBLOCK +: BITPERBLOCK]}
              + {{BITPERBLOCK{1'b0}}, blk_c};
          sum_d[k][k*SW + j*BITPERBLOCK +: BITPERBLOCK] = blk[BITPERBLOCK-1:0];
          blk_c = blk[BITPERBLOCK];
        end
        valid_d[k] = in_v[k];
        carry_d[k] = blk_c;
        a_d[k]     = in_a[k];
        b_d[k]     = in_b[k];
`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
        sign_a_d[k] = in_sa[k];
        sign_b_d[k] = in_sb[k];
`endif
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
      sign_a_q <= '0;
      sign_b_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
`endif
    end
  end

  assign o_valid = valid_q[STAGES-1];
  assign o_s     = sum_q[STAGES-1];
  assign o_c     = carry_q[STAGES-1];

`ifdef PIPELINED_BLOCK_ADDER_FLAGS_EN
  assign o_v = (sign_a_q[STAGES-1] == sign_b_q[STAGES-1]) &&
               (o_s[N-1] != sign_a_q[STAGES-1]);
  // Qualified by valid so the cleared (all-zero) pipeline reports o_z=0.
  assign o_z = o_valid && (o_s == '0);
`else
  assign o_v = 1'b0;
  assign o_z = 1'b0;
`endif

  // The last stage's operand copies have no consumer.
  logic unused_operands;
  assign unused_operands = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: doc/pipelined_block_adder.md
# pipelined_block_adder

Parametrised, pipelined successor to the combinational block-carry adder. Operands are split into `BLOCKCOUNT` blocks of `BITPERBLOCK` bits, and each pipeline stage adds `BLOCKSPERSTAGE` blocks with a registered carry between stages. It adds add/subtract mode, a valid/ready handshake with backpressure, and optional overflow/zero flags. It sits in the ALU datapath wherever a full-width ripple path would break timing.

## Interface
- `BLOCKCOUNT`, 8, number of adder blocks.
- `BITPERBLOCK`, 4, bits per block.
- `N`, 32, operand width; must equal `BLOCKCOUNT*BITPERBLOCK`.
- `BLOCKSPERSTAGE`, 2, blocks evaluated per pipeline stage; must divide `BLOCKCOUNT`.
- Derived: `STAGES = BLOCKCOUNT/BLOCKSPERSTAGE`.
- Clock and reset (already decided): one clock, `i_clk`; reset `i_rst` is asynchronous and active-high.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  operand set valid.
- `o_ready`  out  1  adder accepts the operand set this cycle.
- `i_a`  in  N  operand A.
- `i_b`  in  N  operand B.
- `i_c`  in  1  carry-in; in subtract mode it acts as borrow-in.
- `i_sub`  in  1  0 = A+B+c, 1 = A-B-c.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_s`  out  N  sum/difference.
- `o_c`  out  1  carry-out of the top block (raw, not inverted for subtract).
- `o_v`  out  1  signed overflow.
- `o_z`  out  1  result is zero.

## Operation
- Effective B = `i_sub ? ~i_b : i_b`. Effective carry-in = `i_c ^ i_sub`.
- Stage k adds blocks `[k*BLOCKSPERSTAGE, (k+1)*BLOCKSPERSTAGE-1]`, using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
- Each stage register carries: valid bit; sum bits completed so far; not-yet-added upper A and B bits; inter-stage carry; operand sign bits.
- Final stage: `o_c` = carry-out of the top block. `o_v` = (A[N-1] == effB[N-1]) && (s[N-1] != A[N-1]). `o_z` = (`o_s` == 0).
- Stall: `stall = o_valid & ~i_ready`.
  - When stalled, every stage register holds.
  - Otherwise every stage register advances, and bubbles propagate as valid=0.
- `o_ready = ~stall`. This is combinational from `i_ready`.
- An input transfer occurs when `i_valid & o_ready`; an output transfer occurs when `o_valid & i_ready`. Both may happen in the same cycle.
- Parameter violation (`N != BLOCKCOUNT*BITPERBLOCK`, or `BLOCKCOUNT % BLOCKSPERSTAGE != 0`) triggers `$fatal` at elaboration/start of simulation.

## Timing
- Reset: all valid bits and all data registers are cleared asynchronously.
  - After reset: `o_valid`=0, `o_s`=0, `o_c`=0, `o_v`=0, `o_z`=0.
  - `o_ready`=1, since `o_valid`=0.
- Latency: a transfer accepted at edge t presents its result on `o_valid` after edge t+`STAGES-1`. That is, `STAGES` register stages in total, with the output driven from the last stage.
- Throughput: one operation per cycle while `i_ready`=1.
- Holding under backpressure: `o_s`, `o_c`, `o_v`, `o_z` and `o_valid` are held stable while stalled. No result is dropped or duplicated.
- Reset mid-operation: all in-flight operations are discarded. No result is ever emitted for them.
- `BLOCKSPERSTAGE = BLOCKCOUNT`: single stage, latency 1.

## Configuration
- Macro: `PIPELINED_BLOCK_ADDER_FLAGS_EN`.
- Defined: `o_v` and `o_z` are computed as described under Operation, and sign bits are carried through the pipeline.
- Undefined: `o_v` and `o_z` are tied to 0, and no sign or flag logic is instantiated. `o_s`, `o_c` and the handshake are unchanged.

## Test plan
All scenarios use defaults, so `STAGES`=4.
- Reset, then idle: `o_valid`=0, `o_ready`=1, all outputs 0.
- One transfer, add: A=0x0000_FFFF, B=0x0000_0001, c=0, sub=0 -> exactly 4 cycles later: `o_s`=0x0001_0000, `o_c`=0, `o_z`=0.
- Subtract, back-to-back streaming at `i_ready`=1:
  - 5-5 -> `o_s`=0, `o_c`=1, `o_z`=1.
  - 0-1 -> 0xFFFF_FFFF, `o_c`=0.
  - Both results appear on consecutive cycles.
- Overflow (flags enabled): 0x7FFF_FFFF + 1 -> `o_s`=0x8000_0000, `o_v`=1. 0xFFFF_FFFF + 1 with c=0 -> `o_s`=0, `o_c`=1, `o_v`=0.
- Backpressure: stream 6 operations while holding `i_ready`=0 for 3 cycles after the first `o_valid`.
  - `o_ready`=0 during the stall, and outputs stay stable.
  - All 6 results arrive in order, with none lost.
- Reset asserted with 3 operations in flight: `o_valid` falls immediately, and no stale result appears after reset is released.
